// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative multiply/divide sequencer that owns the HI/LO pair.
// Multiplies use 32 shift-add steps and divides use 32 restoring steps, both
// on unsigned magnitudes; a final FIX cycle restores signs and writes HI/LO.
module muldiv_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [5:0]  req_func,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        req_ready,
  input  logic        flush,
  input  logic        rd_en,
  input  logic        rd_sel,
  output logic [31:0] rd_data,
  output logic        rd_stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t      state;
  state_t      state_next;
  logic [4:0]  count;
  logic [63:0] acc;           // mult: {partial product, multiplier}; div: {rem, quot}
  logic [31:0] operand;       // multiplicand magnitude or divisor magnitude
  logic [31:0] dividend_raw;  // original dividend, returned in HI on divide by zero
  logic        op_div;
  logic        neg_q;         // product sign for mult, quotient sign for div
  logic        neg_r;         // remainder sign (follows the dividend)
  logic        div_zero;

  logic        accept;
  logic        start_mul;
  logic        start_div;
  logic        signed_op;
  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_shift;
  logic [32:0] div_diff;
  logic [63:0] div_next;
  logic [63:0] prod_fix;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;

  assign req_ready = (state == IDLE) && !flush;
  assign busy      = (state != IDLE);
  assign rd_stall  = rd_en && busy;
  assign rd_data   = rd_sel ? lo : hi;

  assign accept    = req_valid && req_ready;
  assign start_mul = accept && ((req_func == F_MULT) || (req_func == F_MULTU));
  assign start_div = accept && ((req_func == F_DIV) || (req_func == F_DIVU));
  assign signed_op = (req_func == F_MULT) || (req_func == F_DIV);
  assign a_abs     = (signed_op && req_a[31]) ? -req_a : req_a;
  assign b_abs     = (signed_op && req_b[31]) ? -req_b : req_b;

  // One shift-add multiply step: conditional add into the upper half, then shift right keeping the carry
  always_comb begin
    mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, operand} : 33'd0);
    mul_next = {mul_sum, acc[31:1]};
  end

  // One restoring divide step: shift {rem,quot} left, trial-subtract, keep the difference if non-negative
  always_comb begin
    div_shift = acc[63:31];
    div_diff  = div_shift - {1'b0, operand};
    if (div_diff[32]) begin
      div_next = {div_shift[31:0], acc[30:0], 1'b0};
    end else begin
      div_next = {div_diff[31:0], acc[30:0], 1'b1};
    end
  end

  // Sign restoration applied to the finished magnitudes in the FIX cycle
  always_comb begin
    prod_fix = neg_q ? -acc : acc;
    quot_fix = neg_q ? -acc[31:0] : acc[31:0];
    rem_fix  = neg_r ? -acc[63:32] : acc[63:32];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a flush returns any active state to IDLE
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_mul) begin
          state_next = MUL;
        end else if (start_div) begin
          state_next = DIV;
        end
      end
      MUL:     if (count == 5'd31) state_next = FIX;
      DIV:     if (count == 5'd31) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush && (state != IDLE)) begin
      state_next = IDLE;
    end
  end

  // Operand latching at accept and the per-cycle iteration of the accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count        <= 5'd0;
      acc          <= 64'd0;
      operand      <= 32'd0;
      dividend_raw <= 32'd0;
      op_div       <= 1'b0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      div_zero     <= 1'b0;
    end else begin
      if (((state == MUL) || (state == DIV)) && !flush) begin
        count <= count + 5'd1;
      end else begin
        count <= 5'd0;
      end
      if (start_mul) begin
        acc     <= {32'd0, b_abs};
        operand <= a_abs;
        op_div  <= 1'b0;
        neg_q   <= signed_op && (req_a[31] ^ req_b[31]);
        neg_r   <= 1'b0;
      end else if (start_div) begin
        acc          <= {32'd0, a_abs};
        operand      <= b_abs;
        op_div       <= 1'b1;
        neg_q        <= signed_op && (req_a[31] ^ req_b[31]);
        neg_r        <= signed_op && req_a[31];
        div_zero     <= (req_b == 32'd0);
        dividend_raw <= req_a;
      end else if (state == MUL) begin
        acc <= mul_next;
      end else if (state == DIV) begin
        acc <= div_next;
      end
    end
  end

  // HI/LO writes from mthi/mtlo and from a completed (unflushed) FIX cycle, plus the done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi   <= 32'd0;
      lo   <= 32'd0;
      done <= 1'b0;
    end else begin
      done <= (state == FIX) && !flush;
      if (accept && (req_func == F_MTHI)) begin
        hi <= req_a;
      end
      if (accept && (req_func == F_MTLO)) begin
        lo <= req_a;
      end
      if ((state == FIX) && !flush) begin
        if (!op_div) begin
          hi <= prod_fix[63:32];
          lo <= prod_fix[31:0];
        end else if (div_zero) begin
          hi <= dividend_raw;
          lo <= 32'hFFFF_FFFF;
        end else begin
          hi <= rem_fix;
          lo <= quot_fix;
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: table vectors, hand-written corner sequences and random
// operations checked against a plain-arithmetic HI/LO model.
module tb_muldiv_ctrl;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_ADD   = 6'b100000;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic [5:0]  req_func;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        req_ready;
  logic        flush;
  logic        rd_en;
  logic        rd_sel;
  logic [31:0] rd_data;
  logic        rd_stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int          vectors;
  int          miscompares;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  typedef struct {
    logic [5:0]  func;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[13];

  muldiv_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_func  (req_func),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .flush     (flush),
    .rd_en     (rd_en),
    .rd_sel    (rd_sel),
    .rd_data   (rd_data),
    .rd_stall  (rd_stall),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .done      (done)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something hangs outside a bounded wait
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: HI/LO after an operation, straight from the arithmetic definition
  function automatic void ref_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sp;
    logic [63:0] up;
    int          sa;
    int          sb;
    sa = a;
    sb = b;
    case (f)
      F_MULT: begin
        sp = longint'(sa) * longint'(sb);
        {exp_hi, exp_lo} = sp;
      end
      F_MULTU: begin
        up = {32'd0, a} * {32'd0, b};
        {exp_hi, exp_lo} = up;
      end
      F_DIV: begin
        if (b == 32'd0) begin
          exp_hi = a;
          exp_lo = 32'hFFFF_FFFF;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          exp_hi = 32'd0;
          exp_lo = 32'h8000_0000;
        end else begin
          exp_lo = sa / sb;
          exp_hi = sa % sb;
        end
      end
      F_DIVU: begin
        if (b == 32'd0) begin
          exp_hi = a;
          exp_lo = 32'hFFFF_FFFF;
        end else begin
          exp_lo = a / b;
          exp_hi = a % b;
        end
      end
      F_MTHI:  exp_hi = a;
      F_MTLO:  exp_lo = a;
      default: ;
    endcase
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one request at a negedge and advance to the next negedge (cycle 1)
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    req_valid = 1'b1;
    req_func  = f;
    req_a     = a;
    req_b     = b;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Run one operation to completion and update the model; ends in the done cycle for mult/div
  task automatic apply_stimulus(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    int   cycles;
    logic long_op;
    long_op = (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
    check_output("ready_idle", req_ready, 1);
    issue(f, a, b);
    check_output("done_low_cycle1", done, 0);
    check_output("busy_cycle1", busy, long_op);
    if (long_op) begin
      cycles = 1;
      while (!done && cycles < 40) begin
        @(negedge clk);
        cycles++;
      end
      check_output("done_latency", cycles, 34);
      check_output("busy_done_cycle", busy, 0);
    end
    ref_op(f, a, b);
  endtask

  // Main test sequence
  initial begin
    int          bad_done;
    int          pick;
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;

    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    req_valid   = 1'b0;
    req_func    = 6'd0;
    req_a       = 32'd0;
    req_b       = 32'd0;
    flush       = 1'b0;
    rd_en       = 1'b1;
    rd_sel      = 1'b0;
    exp_hi      = 32'd0;
    exp_lo      = 32'd0;

    vecs[0]  = '{F_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[1]  = '{F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2]  = '{F_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{F_DIV,   32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF};
    vecs[4]  = '{F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5]  = '{F_DIVU,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};
    vecs[6]  = '{F_DIVU,  32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[7]  = '{F_MTHI,  32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF, 32'hFFFF_FFFF};
    vecs[8]  = '{F_MTLO,  32'h0BAD_F00D, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0BAD_F00D};
    vecs[9]  = '{F_ADD,   32'h5555_5555, 32'h1111_1111, 32'hDEAD_BEEF, 32'h0BAD_F00D};
    vecs[10] = '{F_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[11] = '{F_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[12] = '{F_MULT,  32'h0001_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_0000};

    // Reset state
    repeat (3) @(negedge clk);
    check_output("reset_hi", hi, 32'd0);
    check_output("reset_lo", lo, 32'd0);
    check_output("reset_busy", busy, 0);
    check_output("reset_done", done, 0);
    check_output("reset_ready", req_ready, 1);
    check_output("reset_rd_stall", rd_stall, 0);
    rst_n = 1'b1;
    rd_en = 1'b0;
    @(negedge clk);

    // Table-driven vectors, issued back to back (mult/div follow-ons start in the done cycle)
    for (int i = 0; i < 13; i++) begin
      apply_stimulus(vecs[i].func, vecs[i].a, vecs[i].b);
      check_output("table_hi", hi, vecs[i].exp_hi);
      check_output("table_lo", lo, vecs[i].exp_lo);
      rd_sel = i[0];
      #1;
      check_output("table_rd_data", rd_data, i[0] ? vecs[i].exp_lo : vecs[i].exp_hi);
    end
    @(negedge clk);

    // Stall while a mult is in flight; a request during busy must be ignored
    rd_en  = 1'b1;
    rd_sel = 1'b1;
    issue(F_MULT, 32'h0000_1234, 32'h0000_0010);
    for (int cyc = 1; cyc <= 33; cyc++) begin
      check_output("rd_stall_busy", rd_stall, 1);
      if (cyc == 5) begin
        req_valid = 1'b1;
        req_func  = F_MTHI;
        req_a     = 32'h0000_0055;
        #1;
        check_output("ready_during_busy", req_ready, 0);
      end
      @(negedge clk);
      req_valid = 1'b0;
    end
    ref_op(F_MULT, 32'h0000_1234, 32'h0000_0010);
    check_output("stall_done", done, 1);
    check_output("stall_released", rd_stall, 0);
    check_output("stall_rd_lo", rd_data, exp_lo);
    check_output("stall_ready", req_ready, 1);
    rd_sel = 1'b0;
    #1;
    check_output("stall_rd_hi", rd_data, exp_hi);
    rd_en = 1'b0;
    @(negedge clk);

    // Flush mid-multiply: HI/LO untouched and no done pulse
    apply_stimulus(F_MTHI, 32'hAAAA_5555, 32'd0);
    check_output("mthi_hi", hi, 32'hAAAA_5555);
    issue(F_MULT, 32'd2, 32'd3);
    for (int cyc = 1; cyc < 10; cyc++) @(negedge clk);
    check_output("busy_before_flush", busy, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_output("busy_after_flush", busy, 0);
    bad_done = 0;
    for (int cyc = 0; cyc < 35; cyc++) begin
      if (done) bad_done++;
      @(negedge clk);
    end
    check_output("flush_no_done", bad_done, 0);
    check_output("flush_hi_kept", hi, 32'hAAAA_5555);
    check_output("flush_lo_kept", lo, exp_lo);

    // Flush in IDLE blocks a simultaneous request
    flush     = 1'b1;
    req_valid = 1'b1;
    req_func  = F_MTHI;
    req_a     = 32'h1111_1111;
    #1;
    check_output("ready_with_flush", req_ready, 0);
    @(negedge clk);
    flush     = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    check_output("flush_blocks_mthi", hi, 32'hAAAA_5555);

    // Asynchronous reset in the middle of a divide
    issue(F_DIV, 32'h7777_0000, 32'd3);
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async_reset_busy", busy, 0);
    check_output("async_reset_hi", hi, 32'd0);
    check_output("async_reset_lo", lo, 32'd0);
    check_output("async_reset_ready", req_ready, 1);
    @(negedge clk);
    rst_n  = 1'b1;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    @(negedge clk);

    // Random operations against the model
    for (int n = 0; n < 40; n++) begin
      pick = $urandom_range(0, 9);
      a    = $urandom;
      b    = $urandom;
      if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 15);
      case (pick)
        0, 1:    f = F_MULT;
        2:       f = F_MULTU;
        3, 4:    f = F_DIV;
        5:       f = F_DIVU;
        6:       f = F_MTHI;
        7:       f = F_MTLO;
        8:       f = 6'b100001;
        default: begin
          f = F_DIV;
          if ($urandom_range(0, 1) == 0) begin
            a = 32'h8000_0000;
            b = 32'hFFFF_FFFF;
          end else begin
            b = 32'd0;
          end
        end
      endcase
      apply_stimulus(f, a, b);
      check_output("rand_hi", hi, exp_hi);
      check_output("rand_lo", lo, exp_lo);
      rd_sel = $urandom_range(0, 1);
      #1;
      check_output("rand_rd_data", rd_data, rd_sel ? exp_lo : exp_hi);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
